// File: rtl/crt_clock_pkg.sv
// Shared constants for the CRT pixel-clock generator: frequency width, FSM encodings, minimum ratio.
package crt_clock_pkg;

    localparam int unsigned FREQ_W_DEFAULT = 10;
    localparam int unsigned MIN_RATIO      = 2;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_BAD  = 2'd3;

endpackage

// File: rtl/crt_clock_if.sv
// Frequency request / pixel clock bundle between a controller (master) and crt_clock (slave).
// Locked exists only when CRT_CLOCK_LOCK_EN is defined.
interface crt_clock_if #(
    parameter int unsigned FREQ_W = crt_clock_pkg::FREQ_W_DEFAULT
);
    logic [FREQ_W-1:0] SystemClockFreq;
    logic [FREQ_W-1:0] CRTClockFreq;
    logic              PixelClock;
`ifdef CRT_CLOCK_LOCK_EN
    logic              Locked;

    modport master (output SystemClockFreq, output CRTClockFreq, input PixelClock, input Locked);
    modport slave  (input SystemClockFreq, input CRTClockFreq, output PixelClock, output Locked);
`else
    modport master (output SystemClockFreq, output CRTClockFreq, input PixelClock);
    modport slave  (input SystemClockFreq, input CRTClockFreq, output PixelClock);
`endif
endinterface

// File: rtl/crt_clock_div.sv
// Restoring shift-subtract unsigned divider: W iterations after start, then a one-cycle done pulse.
// A start while busy discards the running division and reloads.
module crt_clock_div #(
    parameter int unsigned W = crt_clock_pkg::FREQ_W_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic         done_o
);
    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W:0]       rem_sh;
    logic [W:0]       diff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // One quotient bit per cycle; the remainder is restored when the trial subtraction goes negative.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        rem_sh = {rem_q, quo_q[W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = CNT_W'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/crt_clock.sv
// CRT/VGA pixel clock generator: divides Clock by N = floor(Sys/CRT), computed at run time.
// Optional Locked output is enabled by defining CRT_CLOCK_LOCK_EN.
module crt_clock
    import crt_clock_pkg::*;
#(
    parameter int unsigned FREQ_W = FREQ_W_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset,
    crt_clock_if.slave  bus
);
    state_t            state_q, state_d;
    logic [FREQ_W-1:0] sys_q, sys_d;
    logic [FREQ_W-1:0] crt_q, crt_d;
    logic [FREQ_W-1:0] n_q, n_d;
    logic [FREQ_W-1:0] k_q, k_d;
    logic              pix_q, pix_d;

    logic              changed;
    logic              div_start;
    logic              div_done;
    logic [FREQ_W-1:0] div_quo;
    logic [FREQ_W-1:0] k_inc;
    logic [FREQ_W-1:0] half;

    crt_clock_div #(.W(FREQ_W)) u_div (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .start_i    (div_start),
        .dividend_i (bus.SystemClockFreq),
        .divisor_i  (bus.CRTClockFreq),
        .quotient_o (div_quo),
        .done_o     (div_done)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            sys_q   <= '0;
            crt_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            pix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sys_q   <= sys_d;
            crt_q   <= crt_d;
            n_q     <= n_d;
            k_q     <= k_d;
            pix_q   <= pix_d;
        end
    end

    // k_q is the phase of the PixelClock value currently on the output; high while k < ceil(N/2).
    always_comb begin
        state_d   = state_q;
        sys_d     = sys_q;
        crt_d     = crt_q;
        n_d       = n_q;
        k_d       = k_q;
        pix_d     = pix_q;
        div_start = 1'b0;
        changed   = {bus.SystemClockFreq, bus.CRTClockFreq} != {sys_q, crt_q};
        half      = n_q - (n_q >> 1);
        k_inc     = (k_q == n_q - FREQ_W'(1)) ? '0 : k_q + FREQ_W'(1);

        if (state_q == ST_IDLE || changed) begin
            sys_d = bus.SystemClockFreq;
            crt_d = bus.CRTClockFreq;
            n_d   = '0;
            k_d   = '0;
            pix_d = 1'b0;
            if (bus.CRTClockFreq == '0) begin
                state_d = ST_BAD;
            end else begin
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
        end else begin
            case (state_q)
                ST_DIV: begin
                    if (div_done) begin
                        n_d = div_quo;
                        k_d = '0;
                        if (div_quo >= FREQ_W'(MIN_RATIO)) begin
                            pix_d   = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            pix_d   = 1'b0;
                            state_d = ST_BAD;
                        end
                    end
                end
                ST_RUN: begin
                    k_d   = k_inc;
                    pix_d = k_inc < half;
                end
                default: begin
                    pix_d = 1'b0;
                    k_d   = '0;
                end
            endcase
        end
    end

    assign bus.PixelClock = pix_q;

`ifdef CRT_CLOCK_LOCK_EN
    logic locked_q;

    // Registered alongside the state so Locked rises on the same edge as the first PixelClock pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= (state_d == ST_RUN);
        end
    end

    assign bus.Locked = locked_q;
`endif

endmodule

// File: tb/tb_crt_clock.sv
// Directed bench for crt_clock: captures 32 PixelClock samples from each (re)start edge
// and compares against hand-written waveforms (11 cycles of division latency, then the pattern).
`timescale 1ns/1ps
module tb_crt_clock;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    crt_clock_if #(.FREQ_W(10)) bus ();

    crt_clock #(.FREQ_W(10)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #4 Clock = ~Clock;

    // Sample i sits at bit 31-i; sample 0 is taken just after the (re)start edge.
    localparam logic [31:0] WAVE_N4   = 32'b00000000000_11001100110011001100_1;
    localparam logic [31:0] WAVE_N5   = 32'b00000000000_111001110011100111001;
    localparam logic [31:0] WAVE_N2   = 32'b00000000000_101010101010101010101;
    localparam logic [31:0] WAVE_N3   = 32'b00000000000_110110110110110110110;
    localparam logic [31:0] WAVE_ZERO = 32'h0000_0000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic capture(output logic [31:0] wave);
        wave = '0;
        for (int i = 0; i < 32; i++) begin
            @(posedge Clock);
            #1;
            wave[31-i] = bus.PixelClock;
        end
    endtask

    task automatic check_locked(input string tag, input logic exp);
`ifdef CRT_CLOCK_LOCK_EN
        check_eq(tag, 32'(bus.Locked), 32'(exp));
`else
        check_eq(tag, 32'(bus.PixelClock === 1'bx), 32'(exp & 1'b0));
`endif
    endtask

    task automatic set_freq(input logic [9:0] sys, input logic [9:0] crt);
        @(negedge Clock);
        bus.SystemClockFreq = sys;
        bus.CRTClockFreq    = crt;
    endtask

    logic [31:0] wave;

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        bus.SystemClockFreq = 10'd100;
        bus.CRTClockFreq    = 10'd25;

        repeat (3) @(posedge Clock);
        #1;
        check_eq("reset_pix", 32'(bus.PixelClock), 32'd0);
        check_locked("reset_locked", 1'b0);

        @(negedge Clock);
        Reset = 1'b0;
        capture(wave);
        check_eq("n4_wave", wave, WAVE_N4);
        check_locked("n4_locked", 1'b1);

        // Change while running: drop on the next edge, then N=2
        set_freq(10'd100, 10'd50);
        capture(wave);
        check_eq("n2_wave", wave, WAVE_N2);
        check_locked("n2_locked", 1'b1);

        set_freq(10'd100, 10'd20);
        capture(wave);
        check_eq("n5_wave", wave, WAVE_N5);
        check_locked("n5_locked", 1'b1);

        set_freq(10'd9, 10'd3);
        capture(wave);
        check_eq("n3_wave", wave, WAVE_N3);

        set_freq(10'd100, 10'd0);
        capture(wave);
        check_eq("crt0_wave", wave, WAVE_ZERO);
        check_locked("crt0_locked", 1'b0);

        set_freq(10'd100, 10'd60);
        capture(wave);
        check_eq("n1_wave", wave, WAVE_ZERO);
        check_locked("n1_locked", 1'b0);

        // Input change mid-division: only the newest request counts
        set_freq(10'd100, 10'd25);
        wave = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            wave[i] = bus.PixelClock;
        end
        check_eq("middiv_quiet", wave, WAVE_ZERO);
        set_freq(10'd100, 10'd20);
        capture(wave);
        check_eq("middiv_n5_wave", wave, WAVE_N5);

        // Reset mid-pattern
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_eq("midrst_pix", 32'(bus.PixelClock), 32'd0);
        check_locked("midrst_locked", 1'b0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        capture(wave);
        check_eq("postrst_n5_wave", wave, WAVE_N5);
        check_locked("postrst_locked", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
